fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one FIFO write port among `NUM_REQ` producers. Each producer presents data over a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `MAX_BURST` beats, or until the producer marks its last beat. It drives the FIFO's `wr_en`/`data_in` and never writes while the FIFO reports `full`. It sits directly in front of the FIFO instance, on the same clock.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_picker.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO port arbiters (write side now, read side later).
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

    // Modulo-num_req increment used for round-robin pointer wrap.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_req);
        return (idx + 1 >= num_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first set request at or after rr_ptr,
// scanning upward and wrapping at NUM_REQ.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   pick_idx
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        found    = 1'b0;
        pick_idx = '0;
        cand     = rr_ptr;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
            cand = IDX_W'(rr_next(32'(cand), NUM_REQ));
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// A grant lasts up to MAX_BURST beats or until the producer flags its last beat.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_t       state;
    arb_state_t       next_state;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic             found;
    logic [IDX_W-1:0] pick_idx;
    logic             xfer;
    logic             burst_end;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .found     (found),
        .pick_idx  (pick_idx)
    );

    // A beat moves only when the granted producer is valid and the FIFO has room;
    // last and the burst limit landing together still form a single burst end.
    assign xfer      = (state == ARB_BURST) && req_valid[grant_id] && !fifo_full;
    assign burst_end = xfer && (req_last[grant_id] || (beat_cnt == CNT_W'(MAX_BURST - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:  if (found)     next_state = ARB_BURST;
            ARB_BURST: if (burst_end) next_state = ARB_IDLE;
            default:                  next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            if (found) begin
                grant_id <= pick_idx;
                beat_cnt <= '0;
            end
        end else if (xfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (burst_end) begin
                rr_ptr <= IDX_W'(rr_next(32'(grant_id), NUM_REQ));
            end
        end
    end

    always_comb begin
        fifo_wr_en   = 1'b0;
        req_ready    = '0;
        fifo_data_in = '0;
        grant_valid  = (state == ARB_BURST);
        if (state == ARB_BURST) begin
            fifo_wr_en          = xfer;
            req_ready[grant_id] = xfer;
            fifo_data_in        = req_data[32'(grant_id)*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer beat queues, a depth-8 FIFO model and a
// transaction-level reference arbiter checked against the DUT on every cycle.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int FIFO_WIDTH = 16;
    localparam int MAX_BURST  = 4;
    localparam int IDX_W      = 2;
    localparam int FIFO_DEPTH = 8;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          grant_valid;
    logic [IDX_W-1:0]              grant_id;

    int checks = 0;
    int errors = 0;

    logic [16:0]        pq [NUM_REQ][$];
    logic [NUM_REQ-1:0] en;
    logic [NUM_REQ-1:0] accept_mask;
    logic               rd_en;
    logic               cmp_en;

    logic [15:0] fifo_q [$];
    logic [15:0] popped [$];
    int          fifo_cnt = 0;

    int m_owner = -1;
    int m_beats = 0;
    int m_next  = 0;

    assign fifo_full = (fifo_cnt == FIFO_DEPTH);

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .FIFO_WIDTH (FIFO_WIDTH),
        .MAX_BURST  (MAX_BURST),
        .IDX_W      (IDX_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents the head of each enabled producer queue; a beat is retired once accepted.
    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [16:0] beat;
            if (accept_mask[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            if (en[i] && pq[i].size() > 0) begin
                beat = pq[i][0];
                req_valid[i] = 1'b1;
                req_last[i]  = beat[16];
                req_data[i*FIFO_WIDTH +: FIFO_WIDTH] = beat[15:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[i*FIFO_WIDTH +: FIFO_WIDTH] = '0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            applyStimulus();
        end
    end

    // Reference arbiter, FIFO model and handshake capture, all sampling pre-edge values.
    initial begin
        forever begin
            @(posedge clk);
            accept_mask = req_valid & req_ready;
            if (rst) begin
                m_owner = -1;
                m_next  = 0;
            end else if (m_owner < 0) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (m_owner < 0 && req_valid[(m_next + i) % NUM_REQ]) begin
                        m_owner = (m_next + i) % NUM_REQ;
                        m_beats = 0;
                    end
                end
            end else if (req_valid[m_owner] && !fifo_full) begin
                m_beats++;
                if (req_last[m_owner] || m_beats == MAX_BURST) begin
                    m_next  = (m_owner + 1) % NUM_REQ;
                    m_owner = -1;
                end
            end
            if (rst) begin
                fifo_q.delete();
            end else begin
                if (rd_en && fifo_q.size() > 0) popped.push_back(fifo_q.pop_front());
                if (fifo_wr_en) fifo_q.push_back(fifo_data_in);
            end
            fifo_cnt <= fifo_q.size();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                logic [NUM_REQ-1:0] exp_ready;
                logic               exp_wr;
                logic [15:0]        exp_data;
                exp_ready = '0;
                exp_wr    = 1'b0;
                exp_data  = '0;
                if (m_owner >= 0) begin
                    exp_data = req_data[m_owner*FIFO_WIDTH +: FIFO_WIDTH];
                    if (req_valid[m_owner] && !fifo_full) begin
                        exp_wr = 1'b1;
                        exp_ready[m_owner] = 1'b1;
                    end
                end
                checkOutput("model_grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
                if (m_owner >= 0) checkOutput("model_grant_id", 32'(grant_id), m_owner);
                checkOutput("model_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
                checkOutput("model_req_ready", 32'(req_ready), 32'(exp_ready));
                checkOutput("model_data_in", 32'(fifo_data_in), 32'(exp_data));
            end
        end
    end

    task automatic resetDut(input int cycles);
        rst   = 1'b1;
        rd_en = 1'b0;
        en    = '0;
        for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        popped.delete();
    endtask

    task automatic waitGrantStart(input logic [IDX_W-1:0] exp_id, input string name);
        logic prev;
        logic hit;
        prev = grant_valid;
        hit  = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (grant_valid && !prev) hit = 1'b1;
            else prev = grant_valid;
        end
        checkOutput(name, 32'({hit, grant_id}), 32'({1'b1, exp_id}));
    endtask

    task automatic waitQueueSize(input int idx, input int size, input string name);
        for (int c = 0; c < 60 && pq[idx].size() != size; c++) @(negedge clk);
        checkOutput(name, pq[idx].size(), size);
    endtask

    initial begin
        logic [15:0] exp_s2 [12];
        int c;

        rst         = 1'b1;
        rd_en       = 1'b0;
        cmp_en      = 1'b0;
        accept_mask = '0;
        req_valid   = '0;
        req_last    = '0;
        req_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) pq[i].push_back({1'b1, 16'hD0D0 + 16'(i)});
        en = 4'hF;
        applyStimulus();

        // Reset with every producer requesting, then in-order single-beat grants.
        @(negedge clk);
        cmp_en = 1'b1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        checkOutput("rst_grant_valid", 32'(grant_valid), 32'h0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'h0);
        checkOutput("rst_data_in", 32'(fifo_data_in), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("release_idle", 32'(grant_valid), 32'h0);
        @(negedge clk);
        checkOutput("first_grant_valid", 32'(grant_valid), 32'h1);
        checkOutput("first_grant_id", 32'(grant_id), 32'h0);
        checkOutput("first_wr_en", 32'(fifo_wr_en), 32'h1);
        checkOutput("first_data", 32'(fifo_data_in), 32'hD0D0);
        checkOutput("first_ready", 32'(req_ready), 32'h1);
        waitGrantStart(2'd1, "s1_grant_1");
        waitGrantStart(2'd2, "s1_grant_2");
        waitGrantStart(2'd3, "s1_grant_3");

        // Round robin between req1 and req3 with full-length bursts.
        resetDut(1);
        rd_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            pq[1].push_back({1'b0, 16'h1000 + 16'(k)});
            pq[3].push_back({1'b0, 16'h3000 + 16'(k)});
        end
        en = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            exp_s2[k]     = 16'h1001 + 16'(k);
            exp_s2[k + 4] = 16'h3001 + 16'(k);
            exp_s2[k + 8] = 16'h1005 + 16'(k);
        end
        c = 0;
        while (c < 80 && popped.size() < 12) begin
            @(negedge clk);
            c++;
        end
        checkOutput("s2_pop_count", popped.size(), 12);
        for (int k = 0; k < 12 && k < popped.size(); k++) checkOutput("s2_order", 32'(popped[k]), 32'(exp_s2[k]));

        // Short packet from req2, then the scan wraps to req0.
        resetDut(1);
        rd_en = 1'b1;
        pq[1].push_back({1'b1, 16'h1111});
        en = 4'b0010;
        waitQueueSize(1, 0, "s3_req1_done");
        pq[2].push_back({1'b0, 16'h00A1});
        pq[2].push_back({1'b1, 16'h00A2});
        pq[0].push_back({1'b1, 16'h0B01});
        en = 4'b0101;
        waitGrantStart(2'd2, "s3_grant_req2");
        checkOutput("s3_beat1", 32'({fifo_wr_en, fifo_data_in}), 32'h100A1);
        @(negedge clk);
        checkOutput("s3_beat2", 32'({fifo_wr_en, fifo_data_in}), 32'h100A2);
        @(negedge clk);
        checkOutput("s3_bubble", 32'(grant_valid), 32'h0);
        @(negedge clk);
        checkOutput("s3_wrap_grant", 32'({grant_valid, grant_id}), 32'h4);
        repeat (4) @(negedge clk);
        checkOutput("s3_pop_count", popped.size(), 4);
        if (popped.size() >= 4) begin
            checkOutput("s3_pop0", 32'(popped[0]), 32'h1111);
            checkOutput("s3_pop1", 32'(popped[1]), 32'h00A1);
            checkOutput("s3_pop2", 32'(popped[2]), 32'h00A2);
            checkOutput("s3_pop3", 32'(popped[3]), 32'h0B01);
        end

        // Full backpressure: fill 8 entries, then free one slot at a time.
        resetDut(1);
        for (int k = 0; k < 12; k++) pq[0].push_back({1'b0, 16'h0C00 + 16'(k)});
        en = 4'b0001;
        c = 0;
        while (c < 60 && fifo_cnt != FIFO_DEPTH) begin
            @(negedge clk);
            c++;
        end
        checkOutput("s4_filled", fifo_cnt, FIFO_DEPTH);
        repeat (3) begin
            @(negedge clk);
            checkOutput("s4_full_hold", 32'({grant_valid, grant_id, fifo_wr_en, req_ready}), 32'h80);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checkOutput("s4_slot_write", 32'({fifo_wr_en, fifo_data_in}), 32'h10C08);
        checkOutput("s4_slot_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        checkOutput("s4_full_again", 32'({grant_valid, fifo_wr_en}), 32'h2);
        rd_en = 1'b1;
        waitQueueSize(0, 0, "s4_drained");
        checkOutput("s4_burst_end", 32'(grant_valid), 32'h0);
        repeat (15) @(negedge clk);
        checkOutput("s4_pop_count", popped.size(), 12);
        if (popped.size() >= 12) begin
            checkOutput("s4_pop0", 32'(popped[0]), 32'h0C00);
            checkOutput("s4_pop8", 32'(popped[8]), 32'h0C08);
            checkOutput("s4_pop11", 32'(popped[11]), 32'h0C0B);
        end

        // Reset in the middle of a req1 burst; round robin restarts from index 0.
        resetDut(1);
        rd_en = 1'b1;
        pq[2].push_back({1'b1, 16'h2501});
        en = 4'b0100;
        waitQueueSize(2, 0, "s5_req2_done");
        for (int k = 1; k <= 4; k++) pq[1].push_back({1'b0, 16'h1500 + 16'(k)});
        en = 4'b0010;
        c = 0;
        while (c < 40 && !(fifo_wr_en && fifo_data_in == 16'h1502)) begin
            @(negedge clk);
            c++;
        end
        checkOutput("s5_reach_beat2", 32'({fifo_wr_en, fifo_data_in}), 32'h11502);
        rst = 1'b1;
        pq[3].push_back({1'b1, 16'h3501});
        en = 4'b1010;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("s5_after_rst", 32'({grant_valid, fifo_wr_en, req_ready}), 32'h0);
        waitGrantStart(2'd1, "s5_rr_restart");

        // Valid gap mid-burst: grant held, burst finishes when valid returns.
        resetDut(1);
        rd_en = 1'b1;
        for (int k = 1; k <= 4; k++) pq[3].push_back({1'b0, 16'h3600 + 16'(k)});
        en = 4'b1000;
        waitQueueSize(3, 2, "s6_two_beats");
        en = 4'b0000;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            checkOutput("s6_gap_hold", 32'({grant_valid, grant_id, fifo_wr_en}), 32'hE);
        end
        en = 4'b1000;
        @(negedge clk);
        checkOutput("s6_resume", 32'({fifo_wr_en, fifo_data_in}), 32'h13604);
        @(negedge clk);
        checkOutput("s6_end", 32'(grant_valid), 32'h0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
